scpad_be_row_assembler: RTL and testbench
=========================================

// Module: scpad_be_row_assembler
// PURPOSE
//  Backend read-path stage between the DRAM controller response port and the scratchpad SRAM write port.
//  Collects tagged 64-bit DRAM read beats, which may arrive out of order, into one full scratchpad row.
//  Emits the row as a single sram_write_req_t, with identity crossbar descriptors, toward the xbar/SRAM.
//  One row job is in flight at a time; the backend scheduler issues one job per row.
// PARAMETERS (all from scpad_pkg)
//  NUM_COLS           32  lanes per row; MAX_DIM_WIDTH = $clog2(NUM_COLS)
//  ELEM_BITS          16  bits per element
//  MAX_DRAM_BUS_BITS  64  DRAM beat width; EPB = MAX_DRAM_BUS_BITS/ELEM_BITS = 4 elements per beat
//  DRAM_ID_WIDTH      8   response id width; BPR = NUM_COLS/EPB = 8 beats per row; BIW = $clog2(BPR) = 3
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  synchronous active-high reset
//  job_valid      in   1                  row job offered
//  job_ready      out  1                  high only in IDLE
//  job_spad_addr  in   SCPAD_ADDR_WIDTH   destination row byte address; bits [ROW_SHIFT-1:0] ignored
//  job_num_cols   in   MAX_DIM_WIDTH      valid elements in the row; 0 encodes NUM_COLS
//  job_tag        in   DRAM_ID_WIDTH-BIW  expected id[DRAM_ID_WIDTH-1:BIW]
//  dram_res       in   $bits(dram_res_t)  DRAM response {valid, write, id, rdata}
//  dram_res_ready out  1                  high in COLLECT only
//  wr_req         out  $bits(sram_write_req_t)  assembled row; wr_req.valid is the request-valid bit
//  wr_ready       in   1                  SRAM side accepts wr_req
//  err_pulse      out  1                  one-cycle flag for a dropped or erroneous beat
// BEHAVIOUR
//  Reset: state=IDLE; job_ready=1; dram_res_ready=0; wr_req all-zero; err_pulse=0; beat bitmap cleared; row buffer zeroed.
//  FSM IDLE -> COLLECT -> WRITE -> IDLE.
//  IDLE:
//   - On job_valid && job_ready, latch addr (low ROW_SHIFT bits forced 0), tag and n = (job_num_cols==0 ? NUM_COLS : job_num_cols).
//   - Compute exp_beats = ceil(n/EPB), 1..BPR. Clear bitmap and row buffer. Go to COLLECT next cycle.
//  COLLECT: a beat is accepted when dram_res.valid && dram_res_ready.
//   - Beat index b = id[BIW-1:0]; beat tag = id[DRAM_ID_WIDTH-1:BIW].
//   - Good beat (write=0, tag match, b<exp_beats, bitmap[b]=0): rdata[16k+:16] -> lane EPB*b+k, k=0..EPB-1; set bitmap[b].
//   - write=1 beats are consumed and dropped silently (no err_pulse).
//   - Tag mismatch, b>=exp_beats, or duplicate b: consumed, data discarded, err_pulse=1 the next cycle.
//   - When the accepted good beat completes bitmap[exp_beats-1:0], go to WRITE. wr_req.valid=1 the cycle after that beat.
//   - Minimum job-accept to wr_req.valid latency is exp_beats+1 cycles.
//  WRITE: hold every wr_req field stable until wr_ready.
//   - wr_req.spad_addr = latched addr; wr_req.wdata = row buffer, with lanes >= n forced 0 even when carried in the last beat.
//   - xbar.valid_mask[i] = (i<n).
//   - xbar.slot_mask[i] = addr[SCPAD_ADDR_WIDTH-1:ROW_SHIFT] for every lane.
//   - xbar.shift_mask[i] = i (identity).
//   - On wr_ready && wr_req.valid: next cycle wr_req.valid=0 and state=IDLE, so job_ready is 1 one cycle after the handshake.
//   - wr_ready while wr_req.valid=0 has no effect.
//  Boundaries:
//   - n=1: exp_beats=1. n=NUM_COLS: exp_beats=BPR.
//   - A new job is never accepted before the previous row handshakes.
//   - Beats presented in IDLE or WRITE are not accepted and stay pending.
//  rst mid-operation: the partial row is discarded, no wr_req is emitted, and the block returns to IDLE.
// TESTING
//  1. job(addr=0x140, num_cols=0, tag=5); 8 beats with ids {5,b}, b=7..0 reversed, rdata=lane-index pattern
//     -> wr_req 1 cycle after 8th beat; wdata lane i = i; valid_mask=32'hFFFF_FFFF; slot_mask all 5 (ROW_BYTES=64);
//     job_ready=1 one cycle after wr_ready.
//  2. job num_cols=6; beats b=1,0 with all-ones rdata -> valid_mask=32'h3F; lanes 6,7 zero; beat count 2.
//  3. job num_cols=6, tag=5; inject tag=4 beat, duplicate b=0, b=3, and a write=1 beat
//     -> err_pulse exactly 3 times; row unaffected; completes only after real b=0,1.
//  4. Row complete with wr_ready=0 for 10 cycles -> wr_req stable; job_ready=0; dram_res_ready=0.
//  5. rst asserted after 3 of 8 beats -> IDLE next cycle; no wr_req.valid.
//     A fresh job completes correctly with its own data only.
//  6. Back-to-back jobs with DRAM beats always valid and wr_ready=1
//     -> no lost beats; second row data correct; job_ready low through each job.

Source files
------------

// File: rtl/scpad_be_row_assembler.sv
// Scratchpad backend row assembler: gathers tagged, possibly out-of-order DRAM read
// beats into one scratchpad row and issues it as a single SRAM write request.
package scpad_pkg;
  localparam int NUM_COLS          = 32;
  localparam int ELEM_BITS         = 16;
  localparam int MAX_DRAM_BUS_BITS = 64;
  localparam int DRAM_ID_WIDTH     = 8;
  localparam int SCPAD_ADDR_WIDTH  = 12;
  localparam int MAX_DIM_WIDTH     = $clog2(NUM_COLS);
  localparam int ROW_BYTES         = NUM_COLS * ELEM_BITS / 8;
  localparam int ROW_SHIFT         = $clog2(ROW_BYTES);
  localparam int EPB               = MAX_DRAM_BUS_BITS / ELEM_BITS;
  localparam int BPR               = NUM_COLS / EPB;
  localparam int BIW               = $clog2(BPR);
  localparam int TAG_WIDTH         = DRAM_ID_WIDTH - BIW;
  localparam int SLOT_WIDTH        = SCPAD_ADDR_WIDTH - ROW_SHIFT;

  typedef struct packed {
    logic                         valid;
    logic                         write;
    logic [DRAM_ID_WIDTH-1:0]     id;
    logic [MAX_DRAM_BUS_BITS-1:0] rdata;
  } dram_res_t;

  typedef struct packed {
    logic [NUM_COLS-1:0]                    valid_mask;
    logic [NUM_COLS-1:0][SLOT_WIDTH-1:0]    slot_mask;
    logic [NUM_COLS-1:0][MAX_DIM_WIDTH-1:0] shift_mask;
  } xbar_desc_t;

  typedef struct packed {
    logic                                valid;
    logic [SCPAD_ADDR_WIDTH-1:0]         spad_addr;
    logic [NUM_COLS-1:0][ELEM_BITS-1:0]  wdata;
    xbar_desc_t                          xbar;
  } sram_write_req_t;
endpackage

module scpad_be_row_assembler
  import scpad_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [SCPAD_ADDR_WIDTH-1:0] job_spad_addr,
  input  logic [MAX_DIM_WIDTH-1:0]    job_num_cols,
  input  logic [TAG_WIDTH-1:0]        job_tag,
  input  dram_res_t                   dram_res,
  output logic                        dram_res_ready,
  output sram_write_req_t             wr_req,
  input  logic                        wr_ready,
  output logic                        err_pulse
);

  localparam int ROW_BITS   = NUM_COLS * ELEM_BITS;
  localparam int CNT_W      = MAX_DIM_WIDTH + 1;
  localparam int BEAT_CNT_W = BIW + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [SCPAD_ADDR_WIDTH-1:0] r_addr;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [CNT_W-1:0]            r_n;
  logic [BEAT_CNT_W-1:0]       r_exp_beats;
  logic [BPR-1:0]              r_bitmap;
  logic [ROW_BITS-1:0]         r_row;
  logic                        r_err;
  sram_write_req_t             r_wr_req;

  logic                        w_job_fire;
  logic [CNT_W-1:0]            w_job_n;
  logic [BEAT_CNT_W-1:0]       w_job_exp;
  logic                        w_beat_fire;
  logic [BIW-1:0]              w_b;
  logic [TAG_WIDTH-1:0]        w_btag;
  logic                        w_good;
  logic                        w_bad;
  logic [BPR-1:0]              w_need;
  logic [BPR-1:0]              w_bitmap_next;
  logic                        w_done;
  logic [ROW_BITS-1:0]         w_row_next;
  sram_write_req_t             w_row_req;

  assign job_ready      = (r_state == S_IDLE);
  assign dram_res_ready = (r_state == S_COLLECT);
  assign wr_req         = r_wr_req;
  assign err_pulse      = r_err;

  assign w_job_fire  = job_valid && job_ready;
  assign w_job_n     = (job_num_cols == '0) ? CNT_W'(NUM_COLS) : {1'b0, job_num_cols};
  assign w_job_exp   = BEAT_CNT_W'((w_job_n + CNT_W'(EPB - 1)) >> $clog2(EPB));

  // write=1 beats are consumed silently; any other non-good beat raises err_pulse
  assign w_beat_fire = dram_res.valid && dram_res_ready;
  assign w_b         = dram_res.id[BIW-1:0];
  assign w_btag      = dram_res.id[DRAM_ID_WIDTH-1:BIW];
  assign w_good      = w_beat_fire && !dram_res.write && (w_btag == r_tag) &&
                       ({1'b0, w_b} < r_exp_beats) && !r_bitmap[w_b];
  assign w_bad       = w_beat_fire && !dram_res.write && !w_good;
  assign w_need      = {BPR{1'b1}} >> (BEAT_CNT_W'(BPR) - r_exp_beats);
  assign w_done      = w_good && ((w_bitmap_next & w_need) == w_need);

  always_comb begin
    w_bitmap_next = r_bitmap;
    w_row_next    = r_row;
    if (w_good) begin
      w_bitmap_next = r_bitmap | (BPR'(1'b1) << w_b);
      w_row_next[int'(w_b) * MAX_DRAM_BUS_BITS +: MAX_DRAM_BUS_BITS] = dram_res.rdata;
    end else begin
      w_bitmap_next = r_bitmap;
      w_row_next    = r_row;
    end
  end

  // Request image built from the row including the completing beat; lanes past n read as zero
  always_comb begin
    w_row_req           = '0;
    w_row_req.valid     = 1'b1;
    w_row_req.spad_addr = r_addr;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (CNT_W'(i) < r_n) begin
        w_row_req.xbar.valid_mask[i] = 1'b1;
        w_row_req.wdata[i]           = w_row_next[i * ELEM_BITS +: ELEM_BITS];
      end else begin
        w_row_req.xbar.valid_mask[i] = 1'b0;
        w_row_req.wdata[i]           = '0;
      end
      w_row_req.xbar.slot_mask[i]  = r_addr[SCPAD_ADDR_WIDTH-1:ROW_SHIFT];
      w_row_req.xbar.shift_mask[i] = MAX_DIM_WIDTH'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_job_fire) w_state_next = S_COLLECT;
        else            w_state_next = S_IDLE;
      end
      S_COLLECT: begin
        if (w_done) w_state_next = S_WRITE;
        else        w_state_next = S_COLLECT;
      end
      S_WRITE: begin
        if (r_wr_req.valid && wr_ready) w_state_next = S_IDLE;
        else                            w_state_next = S_WRITE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_tag       <= '0;
      r_n         <= '0;
      r_exp_beats <= '0;
      r_bitmap    <= '0;
      r_row       <= '0;
      r_err       <= 1'b0;
      r_wr_req    <= '0;
    end else begin
      r_err <= w_bad;
      if (w_job_fire) begin
        r_addr      <= job_spad_addr & {{SLOT_WIDTH{1'b1}}, {ROW_SHIFT{1'b0}}};
        r_tag       <= job_tag;
        r_n         <= w_job_n;
        r_exp_beats <= w_job_exp;
        r_bitmap    <= '0;
        r_row       <= '0;
      end else if (w_good) begin
        r_bitmap <= w_bitmap_next;
        r_row    <= w_row_next;
      end
      if (w_done)                          r_wr_req <= w_row_req;
      else if (r_wr_req.valid && wr_ready) r_wr_req <= '0;
    end
  end

endmodule

// File: tb/tb_scpad_be_row_assembler.sv
// Directed self-checking bench for scpad_be_row_assembler.
module tb_scpad_be_row_assembler;
  import scpad_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        job_valid;
  logic                        job_ready;
  logic [SCPAD_ADDR_WIDTH-1:0] job_spad_addr;
  logic [MAX_DIM_WIDTH-1:0]    job_num_cols;
  logic [TAG_WIDTH-1:0]        job_tag;
  dram_res_t                   dram_res;
  logic                        dram_res_ready;
  sram_write_req_t             wr_req;
  logic                        wr_ready;
  logic                        err_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int wrv_cnt  = 0;

  always #5 clk = ~clk;

  scpad_be_row_assembler dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_spad_addr  (job_spad_addr),
    .job_num_cols   (job_num_cols),
    .job_tag        (job_tag),
    .dram_res       (dram_res),
    .dram_res_ready (dram_res_ready),
    .wr_req         (wr_req),
    .wr_ready       (wr_ready),
    .err_pulse      (err_pulse)
  );

  always @(negedge clk) begin
    if (err_pulse) err_cnt++;
    if (wr_req.valid) wrv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int seed, input int b);
    logic [63:0] d;
    for (int k = 0; k < EPB; k++) d[16*k +: 16] = 16'(seed + EPB*b + k);
    return d;
  endfunction

  function automatic logic [511:0] row_exp(input int seed, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[16*i +: 16] = 16'(seed + i);
    return r;
  endfunction

  function automatic logic [511:0] slot_all(input int s);
    logic [NUM_COLS-1:0][SLOT_WIDTH-1:0] v;
    for (int i = 0; i < NUM_COLS; i++) v[i] = SLOT_WIDTH'(s);
    return 512'(v);
  endfunction

  function automatic logic [511:0] shift_ident();
    logic [NUM_COLS-1:0][MAX_DIM_WIDTH-1:0] v;
    for (int i = 0; i < NUM_COLS; i++) v[i] = MAX_DIM_WIDTH'(i);
    return 512'(v);
  endfunction

  task automatic start_job(input logic [11:0] addr, input logic [4:0] ncols, input logic [4:0] tag);
    int w;
    w = 0;
    while (!job_ready && w < 50) begin
      tick();
      w++;
    end
    check_eq("job_ready_wait", 512'(job_ready), 512'(1'b1));
    job_valid     = 1'b1;
    job_spad_addr = addr;
    job_num_cols  = ncols;
    job_tag       = tag;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic send_beat(input logic wr, input logic [4:0] tag, input int b, input logic [63:0] d);
    dram_res.valid = 1'b1;
    dram_res.write = wr;
    dram_res.id    = {tag, BIW'(b)};
    dram_res.rdata = d;
    tick();
    dram_res = '0;
  endtask

  task automatic handshake();
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    check_eq("hs_valid_low", 512'(wr_req.valid), 512'(1'b0));
    check_eq("hs_job_ready", 512'(job_ready), 512'(1'b1));
  endtask

  logic [511:0] exp_row;
  logic [511:0] rows [2];
  int           base;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_spad_addr = '0; job_num_cols = '0; job_tag = '0;
    dram_res = '0; wr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_job_ready", 512'(job_ready), 512'(1'b1));
    check_eq("rst_dram_ready", 512'(dram_res_ready), 512'(1'b0));
    check_eq("rst_wr_req_zero", 512'(|wr_req), 512'(1'b0));
    check_eq("rst_err", 512'(err_pulse), 512'(1'b0));

    // 1: full row, beats in reverse order
    start_job(12'h140, 5'd0, 5'd5);
    check_eq("t1_job_ready_low", 512'(job_ready), 512'(1'b0));
    check_eq("t1_dram_ready", 512'(dram_res_ready), 512'(1'b1));
    for (int b = 7; b >= 0; b--) begin
      if (b == 0) check_eq("t1_not_early", 512'(wr_req.valid), 512'(1'b0));
      send_beat(1'b0, 5'd5, b, beat_data(0, b));
    end
    check_eq("t1_valid", 512'(wr_req.valid), 512'(1'b1));
    check_eq("t1_wdata", 512'(wr_req.wdata), row_exp(0, 32));
    check_eq("t1_vmask", 512'(wr_req.xbar.valid_mask), 512'(32'hFFFF_FFFF));
    check_eq("t1_slot", 512'(wr_req.xbar.slot_mask), slot_all(5));
    check_eq("t1_shift", 512'(wr_req.xbar.shift_mask), shift_ident());
    check_eq("t1_addr", 512'(wr_req.spad_addr), 512'(12'h140));
    check_eq("t1_job_ready_write", 512'(job_ready), 512'(1'b0));
    handshake();

    // 2: partial row, low address bits ignored
    start_job(12'h085, 5'd6, 5'd3);
    send_beat(1'b0, 5'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("t2_one_beat", 512'(wr_req.valid), 512'(1'b0));
    send_beat(1'b0, 5'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_row = '0;
    for (int i = 0; i < 6; i++) exp_row[16*i +: 16] = 16'hFFFF;
    check_eq("t2_valid", 512'(wr_req.valid), 512'(1'b1));
    check_eq("t2_wdata", 512'(wr_req.wdata), exp_row);
    check_eq("t2_vmask", 512'(wr_req.xbar.valid_mask), 512'(32'h0000_003F));
    check_eq("t2_addr", 512'(wr_req.spad_addr), 512'(12'h080));
    check_eq("t2_slot", 512'(wr_req.xbar.slot_mask), slot_all(2));
    check_eq("t2_dram_ready_low", 512'(dram_res_ready), 512'(1'b0));
    handshake();

    // 3: error beats
    base = err_cnt;
    start_job(12'h040, 5'd6, 5'd5);
    send_beat(1'b0, 5'd4, 0, 64'h1111_1111_1111_1111);
    send_beat(1'b0, 5'd5, 0, beat_data(100, 0));
    send_beat(1'b0, 5'd5, 0, 64'h2222_2222_2222_2222);
    send_beat(1'b0, 5'd5, 3, 64'h3333_3333_3333_3333);
    send_beat(1'b1, 5'd5, 1, 64'h4444_4444_4444_4444);
    check_eq("t3_not_done", 512'(wr_req.valid), 512'(1'b0));
    send_beat(1'b0, 5'd5, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("t3_valid", 512'(wr_req.valid), 512'(1'b1));
    tick(); tick();
    check_eq("t3_err_count", 512'(err_cnt - base), 512'(3));
    exp_row = row_exp(100, 4);
    exp_row[16*4 +: 16] = 16'hFFFF;
    exp_row[16*5 +: 16] = 16'hFFFF;
    check_eq("t3_wdata", 512'(wr_req.wdata), exp_row);
    handshake();

    // 4: backpressure on the write side
    start_job(12'h7C0, 5'd0, 5'd1);
    for (int b = 0; b < 8; b++) send_beat(1'b0, 5'd1, b, beat_data(1000, b));
    check_eq("t4_slot", 512'(wr_req.xbar.slot_mask), slot_all(31));
    check_eq("t4_addr", 512'(wr_req.spad_addr), 512'(12'h7C0));
    job_valid = 1'b1; job_spad_addr = 12'h000; job_num_cols = 5'd1; job_tag = 5'd0;
    dram_res.valid = 1'b1; dram_res.write = 1'b0; dram_res.id = {5'd1, 3'd0};
    dram_res.rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("t4_hold_valid", 512'(wr_req.valid), 512'(1'b1));
      check_eq("t4_hold_wdata", 512'(wr_req.wdata), row_exp(1000, 32));
      check_eq("t4_job_ready", 512'(job_ready), 512'(1'b0));
      check_eq("t4_dram_ready", 512'(dram_res_ready), 512'(1'b0));
    end
    job_valid = 1'b0;
    dram_res = '0;
    check_eq("t4_err_none", 512'(err_pulse), 512'(1'b0));
    handshake();

    // 5: reset mid-collection
    start_job(12'h000, 5'd0, 5'd2);
    for (int b = 0; b < 3; b++) send_beat(1'b0, 5'd2, b, beat_data(500, b));
    base = wrv_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_idle", 512'(job_ready), 512'(1'b1));
    check_eq("t5_dram_ready", 512'(dram_res_ready), 512'(1'b0));
    check_eq("t5_no_valid", 512'(wr_req.valid), 512'(1'b0));
    tick(); tick();
    check_eq("t5_no_wr_cycles", 512'(wrv_cnt - base), 512'(0));
    start_job(12'h100, 5'd10, 5'd2);
    send_beat(1'b0, 5'd2, 2, beat_data(700, 2));
    send_beat(1'b0, 5'd2, 0, beat_data(700, 0));
    send_beat(1'b0, 5'd2, 1, beat_data(700, 1));
    check_eq("t5_valid", 512'(wr_req.valid), 512'(1'b1));
    check_eq("t5_wdata", 512'(wr_req.wdata), row_exp(700, 10));
    check_eq("t5_vmask", 512'(wr_req.xbar.valid_mask), 512'(32'h0000_03FF));
    handshake();

    // 6: back-to-back jobs, beats always offered, wr_ready held high
    begin
      logic [11:0] j_addr [2];
      logic [4:0]  j_cols [2];
      logic [4:0]  j_tag  [2];
      logic [7:0]  b_id   [10];
      logic [63:0] b_data [10];
      int job_idx, beat_idx, nrows, bad;
      logic in_flight, jr, dr, hs;
      j_addr[0] = 12'h200; j_cols[0] = 5'd8; j_tag[0] = 5'd6;
      j_addr[1] = 12'h240; j_cols[1] = 5'd0; j_tag[1] = 5'd7;
      b_id[0] = {5'd6, 3'd1}; b_data[0] = beat_data(2000, 1);
      b_id[1] = {5'd6, 3'd0}; b_data[1] = beat_data(2000, 0);
      for (int j = 0; j < 8; j++) begin
        b_id[2+j]   = {5'd7, 3'(7 - j)};
        b_data[2+j] = beat_data(3000, 7 - j);
      end
      job_idx = 0; beat_idx = 0; nrows = 0; bad = 0; in_flight = 1'b0;
      rows[0] = '0; rows[1] = '0;
      wr_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && nrows < 2; cyc++) begin
        if (wr_req.valid) begin
          if (nrows < 2) rows[nrows] = 512'(wr_req.wdata);
          nrows++;
        end
        if (in_flight && job_ready) bad++;
        job_valid = (job_idx < 2);
        if (job_idx < 2) begin
          job_spad_addr = j_addr[job_idx];
          job_num_cols  = j_cols[job_idx];
          job_tag       = j_tag[job_idx];
        end
        dram_res.valid = (beat_idx < 10);
        dram_res.write = 1'b0;
        if (beat_idx < 10) begin
          dram_res.id    = b_id[beat_idx];
          dram_res.rdata = b_data[beat_idx];
        end
        jr = job_ready; dr = dram_res_ready; hs = wr_req.valid;
        tick();
        if (job_valid && jr) begin
          job_idx++;
          in_flight = 1'b1;
        end
        if (dram_res.valid && dr) beat_idx++;
        if (hs) in_flight = 1'b0;
      end
      job_valid = 1'b0;
      dram_res = '0;
      wr_ready = 1'b0;
      check_eq("t6_rows", 512'(nrows), 512'(2));
      check_eq("t6_row0", rows[0], row_exp(2000, 8));
      check_eq("t6_row1", rows[1], row_exp(3000, 32));
      check_eq("t6_job_ready_low", 512'(bad), 512'(0));
      check_eq("t6_beats", 512'(beat_idx), 512'(10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
